// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one registered-input alu between two requesters, with a
// credit-protected tagged response FIFO. Define ALU_ARB_PERF_EN to add per-port perf counters.
module alu_share_arb #(
    parameter int         WIDTH     = 32,
    parameter int         RSP_DEPTH = 2,
    parameter logic [5:0] IDLE_OP   = 6'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [5:0]       req0_instr,
    input  logic [WIDTH-1:0] req0_rs1,
    input  logic [WIDTH-1:0] req0_rs2,
    input  logic [WIDTH-1:0] req0_imm,
    input  logic [4:0]       req0_shamt,
    input  logic [31:0]      req0_pc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [5:0]       req1_instr,
    input  logic [WIDTH-1:0] req1_rs1,
    input  logic [WIDTH-1:0] req1_rs2,
    input  logic [WIDTH-1:0] req1_imm,
    input  logic [4:0]       req1_shamt,
    input  logic [31:0]      req1_pc,
    output logic [5:0]       alu_instr,
    output logic [WIDTH-1:0] alu_rs1,
    output logic [WIDTH-1:0] alu_rs2,
    output logic [WIDTH-1:0] alu_imm,
    output logic [4:0]       alu_shamt,
    output logic [31:0]      alu_pc,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]      perf_grant0,
    output logic [31:0]      perf_grant1,
    output logic [31:0]      perf_stall0,
    output logic [31:0]      perf_stall1
`endif
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic             prio;
    logic             inflight;
    logic             inflight_id;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] data_mem [RSP_DEPTH];
    logic             id_mem   [RSP_DEPTH];

    logic             grant0, grant1;
    logic             push, pop, can_issue;
    logic [CW:0]      occupancy;

    assign grant0 = req0_valid & (~req1_valid | ~prio);
    assign grant1 = req1_valid & (~req0_valid |  prio);

    assign push = inflight;
    assign pop  = rsp_valid & rsp_ready;

    // Slots already promised (stored + in flight) net of this cycle's pop; this makes
    // rsp_ready combinationally visible on reqN_ready.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign can_issue = occupancy < (CW+1)'(RSP_DEPTH);

    assign req0_ready = ~rst & grant0 & can_issue;
    assign req1_ready = ~rst & grant1 & can_issue;

    assign rsp_valid = ~rst & (count != '0);
    assign rsp_id    = id_mem[rd_ptr];
    assign rsp_data  = data_mem[rd_ptr];

    // NOTE: every output gets a default first so no latch is inferred on the idle path.
    always_comb begin
        alu_instr = IDLE_OP;
        alu_rs1   = '0;
        alu_rs2   = '0;
        alu_imm   = '0;
        alu_shamt = '0;
        alu_pc    = '0;
        if (req0_ready) begin
            alu_instr = req0_instr;
            alu_rs1   = req0_rs1;
            alu_rs2   = req0_rs2;
            alu_imm   = req0_imm;
            alu_shamt = req0_shamt;
            alu_pc    = req0_pc;
        end else if (req1_ready) begin
            alu_instr = req1_instr;
            alu_rs1   = req1_rs1;
            alu_rs2   = req1_rs2;
            alu_imm   = req1_imm;
            alu_shamt = req1_shamt;
            alu_pc    = req1_pc;
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio        <= 1'b0;
            inflight    <= 1'b0;
            inflight_id <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            if (req0_ready)      prio <= 1'b1;
            else if (req1_ready) prio <= 1'b0;
            inflight    <= req0_ready | req1_ready;
            inflight_id <= req1_ready;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: FIFO storage is not reset; count gates rsp_valid so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_mem[wr_ptr] <= alu_out;
            id_mem[wr_ptr]   <= inflight_id;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && count == CW'(RSP_DEPTH)));

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall0 <= '0;
            perf_stall1 <= '0;
        end else begin
            if (req0_ready)               perf_grant0 <= perf_grant0 + 32'd1;
            if (req1_ready)               perf_grant1 <= perf_grant1 + 32'd1;
            if (req0_valid && !req0_ready) perf_stall0 <= perf_stall0 + 32'd1;
            if (req1_valid && !req1_ready) perf_stall1 <= perf_stall1 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: a registered-input alu model, a request driver and a
// monitor that predicts grants, credit and response timing from the arbitration rules.
module tb_alu_share_arb;

    localparam int         WIDTH = 32;
    localparam int         DEPTH = 2;
    localparam logic [5:0] IDLE  = 6'h00;
    localparam logic [5:0] OP_ADD = 6'h01, OP_SUB = 6'h02, OP_AND = 6'h03, OP_OR = 6'h04,
                           OP_XOR = 6'h05, OP_SLL = 6'h06, OP_ADDI = 6'h07, OP_AUIPC = 6'h08;

    typedef struct packed {
        logic [5:0]  instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [31:0] pc;
    } op_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [5:0]  req0_instr = '0, req1_instr = '0;
    logic [31:0] req0_rs1 = '0, req0_rs2 = '0, req0_imm = '0, req0_pc = '0;
    logic [31:0] req1_rs1 = '0, req1_rs2 = '0, req1_imm = '0, req1_pc = '0;
    logic [4:0]  req0_shamt = '0, req1_shamt = '0;
    logic [5:0]  alu_instr;
    logic [31:0] alu_rs1, alu_rs2, alu_imm, alu_pc, alu_out;
    logic [4:0]  alu_shamt;
    logic        rsp_valid, rsp_id;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_stall0, perf_stall1;
`endif

    alu_share_arb #(.WIDTH(WIDTH), .RSP_DEPTH(DEPTH), .IDLE_OP(IDLE)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_imm(req0_imm),
        .req0_shamt(req0_shamt), .req0_pc(req0_pc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_imm(req1_imm),
        .req1_shamt(req1_shamt), .req1_pc(req1_pc),
        .alu_instr(alu_instr), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm),
        .alu_shamt(alu_shamt), .alu_pc(alu_pc), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef ALU_ARB_PERF_EN
        , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
        .perf_stall0(perf_stall0), .perf_stall1(perf_stall1)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(op_t o);
        case (o.instr)
            OP_ADD:   return o.rs1 + o.rs2;
            OP_SUB:   return o.rs1 - o.rs2;
            OP_AND:   return o.rs1 & o.rs2;
            OP_OR:    return o.rs1 | o.rs2;
            OP_XOR:   return o.rs1 ^ o.rs2;
            OP_SLL:   return o.rs1 << o.shamt;
            OP_ADDI:  return o.rs1 + o.imm;
            OP_AUIPC: return o.pc + o.imm;
            default:  return '0;
        endcase
    endfunction

    // Shared alu: registers its inputs, result available the following cycle.
    op_t alu_q;
    always @(posedge clk) alu_q <= {alu_instr, alu_rs1, alu_rs2, alu_imm, alu_shamt, alu_pc};
    assign alu_out = alu_fn(alu_q);

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / reference model state
    exp_t sb[$];
    int   cyc = 0;
    logic favor = 1'b0;
    logic hs_last [2] = '{1'b0, 1'b0};
    int   grant_m [2] = '{0, 0};
    int   stall_m [2] = '{0, 0};
    int   dut_hs_cyc[$];
    logic dut_hs_id[$];

    always @(negedge clk) begin : monitor
        logic exp_valid, pop, can, er0, er1;
        int   outstanding;
        op_t  op0, op1, op;
        exp_t e;
        op0 = {req0_instr, req0_rs1, req0_rs2, req0_imm, req0_shamt, req0_pc};
        op1 = {req1_instr, req1_rs1, req1_rs2, req1_imm, req1_shamt, req1_pc};

        // Oldest accepted op becomes visible two cycles after its handshake.
        exp_valid = !rst && sb.size() > 0 && cyc >= sb[0].cyc + 2;
        check("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_valid});
        pop = exp_valid && rsp_ready;
        outstanding = sb.size() - (pop ? 1 : 0);
        can = outstanding < DEPTH;
        er0 = !rst && req0_valid && (!req1_valid || favor == 1'b0) && can;
        er1 = !rst && req1_valid && (!req0_valid || favor == 1'b1) && can;
        check("req0_ready", {63'd0, req0_ready}, {63'd0, er0});
        check("req1_ready", {63'd0, req1_ready}, {63'd0, er1});

        if (pop) begin
            check("rsp_id",   {63'd0, rsp_id}, {63'd0, sb[0].id});
            check("rsp_data", {32'd0, rsp_data}, {32'd0, sb[0].data});
            void'(sb.pop_front());
        end

        if (req0_valid && req0_ready) begin dut_hs_cyc.push_back(cyc); dut_hs_id.push_back(1'b0); end
        if (req1_valid && req1_ready) begin dut_hs_cyc.push_back(cyc); dut_hs_id.push_back(1'b1); end

        hs_last[0] = er0;
        hs_last[1] = er1;
        if (er0 || er1) begin
            op     = er1 ? op1 : op0;
            e.id   = er1;
            e.data = alu_fn(op);
            e.cyc  = cyc;
            sb.push_back(e);
            favor = !er1 ? 1'b1 : 1'b0;
            grant_m[er1 ? 1 : 0]++;
            check("alu_instr", {58'd0, alu_instr}, {58'd0, op.instr});
            check("alu_rs1",   {32'd0, alu_rs1},   {32'd0, op.rs1});
        end else begin
            check("alu_idle_instr", {58'd0, alu_instr}, {58'd0, IDLE});
            check("alu_idle_rs1",   {32'd0, alu_rs1},   64'd0);
        end
        if (!rst) begin
            if (req0_valid && !er0) stall_m[0]++;
            if (req1_valid && !er1) stall_m[1]++;
        end else begin
            sb.delete();
            favor = 1'b0;
            grant_m = '{0, 0};
            stall_m = '{0, 0};
        end
        cyc++;
    end

    // Driver state
    op_t  pend0[$], pend1[$];
    op_t  cur [2];
    logic hold [2] = '{1'b0, 1'b0};
    int   vprob [2] = '{100, 100};
    int   rprob = 100;

    function automatic op_t mk_op(logic [5:0] instr, logic [31:0] a, logic [31:0] b);
        op_t o;
        o.instr = instr; o.rs1 = a; o.rs2 = b;
        o.imm = $urandom; o.shamt = 5'($urandom); o.pc = $urandom;
        return o;
    endfunction

    function automatic op_t rand_op();
        return mk_op(6'($urandom_range(0, 9)), $urandom, $urandom);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (hs_last[p]) hold[p] = 1'b0;
            if (!hold[p] && $urandom_range(99) < vprob[p]) begin
                if (p == 0 && pend0.size() > 0) begin cur[0] = pend0.pop_front(); hold[0] = 1'b1; end
                if (p == 1 && pend1.size() > 0) begin cur[1] = pend1.pop_front(); hold[1] = 1'b1; end
            end
        end
        req0_valid = hold[0];
        {req0_instr, req0_rs1, req0_rs2, req0_imm, req0_shamt, req0_pc} = cur[0];
        req1_valid = hold[1];
        {req1_instr, req1_rs1, req1_rs2, req1_imm, req1_shamt, req1_pc} = cur[1];
        rsp_ready = (rprob >= 100) ? 1'b1 : (rprob <= 0) ? 1'b0 : ($urandom_range(99) < rprob);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        hold = '{1'b0, 1'b0};
        pend0.delete();
        pend1.delete();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic wait_idle(int max_cycles, string name);
        int k = 0;
        while ((sb.size() > 0 || hold[0] || hold[1] || pend0.size() > 0 || pend1.size() > 0)
               && k < max_cycles) begin
            cycle();
            k++;
        end
        if (k >= max_cycles) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: not idle after %0d cycles, %0d responses outstanding", name, k, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        do_reset();

        // Single op: add 5+7 on port 0, response exactly two cycles after handshake.
        rprob = 100;
        vprob = '{100, 100};
        dut_hs_cyc.delete(); dut_hs_id.delete();
        pend0.push_back(mk_op(OP_ADD, 32'd5, 32'd7));
        k = 0;
        do begin cycle(); k++; end while (!rsp_valid && k < 10);
        check("single_rsp_seen", {63'd0, rsp_valid}, 64'd1);
        if (dut_hs_cyc.size() > 0)
            check("single_latency", 64'(cyc - dut_hs_cyc[0]), 64'd2);
        check("single_data", {32'd0, rsp_data}, 64'd12);
        check("single_id", {63'd0, rsp_id}, 64'd0);
        wait_idle(20, "single_drain");

        // Both ports streaming 8 ops each: strict alternation, no idle cycle.
        do_reset();
        dut_hs_cyc.delete(); dut_hs_id.delete();
        for (int i = 0; i < 8; i++) begin pend0.push_back(rand_op()); pend1.push_back(rand_op()); end
        wait_idle(60, "stream_drain");
        check("stream_count", 64'(dut_hs_id.size()), 64'd16);
        if (dut_hs_id.size() == 16) begin
            for (int i = 0; i < 16; i++) check("stream_order", {63'd0, dut_hs_id[i]}, 64'(i % 2));
            check("stream_span", 64'(dut_hs_cyc[15] - dut_hs_cyc[0]), 64'd15);
        end

        // Consumer stalled: exactly DEPTH handshakes, then ready drops.
        dut_hs_cyc.delete(); dut_hs_id.delete();
        rprob = 0;
        for (int i = 0; i < 5; i++) pend0.push_back(rand_op());
        repeat (8) cycle();
        #1;
        check("stall_handshakes", 64'(dut_hs_id.size()), 64'(DEPTH));
        check("stall_ready0", {63'd0, req0_ready}, 64'd0);

        // Full FIFO released: pop and issue happen in the same cycle.
        rprob = 100;
        cycle();
        #1;
        check("resume_ready0", {63'd0, req0_ready}, 64'd1);
        pend1.push_back(rand_op());
        pend1.push_back(rand_op());
        wait_idle(40, "resume_drain");

        // Reset right after a port-1 issue discards it; port 0 wins next.
        pend1.push_back(mk_op(OP_SUB, 32'd9, 32'd4));
        k = 0;
        do begin cycle(); k++; end while ((hold[1] || pend1.size() > 0) && k < 20);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("no_rsp_after_rst", {63'd0, rsp_valid}, 64'd0);
        end
        pend0.push_back(rand_op());
        pend1.push_back(rand_op());
        cycle();
        #1;
        check("post_rst_grant0", {63'd0, req0_ready}, 64'd1);
        check("post_rst_grant1", {63'd0, req1_ready}, 64'd0);
        wait_idle(20, "post_rst_drain");

        // Randomised traffic with a random consumer.
        for (int blk = 0; blk < 10; blk++) begin
            vprob = '{$urandom_range(20, 100), $urandom_range(20, 100)};
            rprob = $urandom_range(30, 99);
            for (int i = 0; i < 50; i++) begin
                if (pend0.size() < 2) pend0.push_back(rand_op());
                if (pend1.size() < 2) pend1.push_back(rand_op());
                cycle();
            end
        end
        rprob = 100;
        vprob = '{100, 100};
        wait_idle(100, "random_drain");

`ifdef ALU_ARB_PERF_EN
        // Port 0 fills the FIFO, stalls 3 cycles, then completes 4 grants in total.
        do_reset();
        rprob = 0;
        for (int i = 0; i < 4; i++) pend0.push_back(rand_op());
        k = 0;
        do begin cycle(); k++; end while (stall_m[0] < 3 && k < 20);
        rprob = 100;
        rsp_ready = 1'b1;
        wait_idle(30, "perf_drain");
        check("perf_stall0", {32'd0, perf_stall0}, 64'(stall_m[0]));
        check("perf_grant0", {32'd0, perf_grant0}, 64'(grant_m[0]));
        check("perf_stall1", {32'd0, perf_stall1}, 64'(stall_m[1]));
        check("perf_grant1", {32'd0, perf_grant1}, 64'(grant_m[1]));
`endif

        repeat (3) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
